vga_bar_scheduler: RTL

- Per-frame motion controller for the horizontal colour bars drawn by the VGA pixel pipeline.
- On each new-frame tick it updates every bar's vertical offset in turn, one bar per cycle, through a single shared add/bounce datapath.
- It then publishes all offsets together, so the colour logic never sees a half-updated frame.
- It sits between the timing generator's new-frame pulse and the colour-select logic, and replaces the per-bar free-running position counters.

---
 rtl/vga_bar_scheduler.sv | 134 +++++++++++++
 1 files changed

// File: rtl/vga_bar_scheduler.sv
// Per-frame bar motion scheduler: one shared add/bounce datapath walks every bar, then all offsets publish at once.
// Optional wrap mode (direction ignored, overflow wraps to the negative side) is enabled by defining BAR_SCHED_WRAP_EN.
module vga_bar_scheduler #(
  parameter int NUM_BARS      = 3,
  parameter int POS_W         = 9,
  parameter int AMP           = 200,
  parameter int PHASE_SPACING = 15
) (
  input  logic                      i_Clk,
  input  logic                      i_Rst_L,
  input  logic                      i_NewFrameTick,
  input  logic                      i_Pause,
  input  logic [3:0]                i_Step,
  output logic [NUM_BARS*POS_W-1:0] o_BarPos,
  output logic                      o_Busy,
  output logic                      o_UpdateDone,
  output logic                      o_MissedTick,
  output logic [1:0]                o_DbgState
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_UPDATE = 2'd1;
  localparam logic [1:0] S_COMMIT = 2'd2;

  localparam int IDX_W = (NUM_BARS > 1) ? $clog2(NUM_BARS) : 1;
  localparam int EXT_W = POS_W + 2;
  localparam logic [IDX_W-1:0]        LAST_IDX = IDX_W'(NUM_BARS - 1);
  localparam logic signed [EXT_W-1:0] AMP_POS  = EXT_W'(AMP);
`ifdef BAR_SCHED_WRAP_EN
  localparam logic signed [EXT_W-1:0] WRAP_SPAN = EXT_W'(2 * AMP + 1);
`else
  localparam logic signed [EXT_W-1:0] AMP_NEG  = EXT_W'(-AMP);
`endif

  logic [1:0]       state_q;
  logic [IDX_W-1:0] idx_q;
  logic [3:0]       step_q;
  logic [POS_W-1:0] shadow_q [NUM_BARS];
  logic [NUM_BARS*POS_W-1:0] bar_pos_q;
  logic             done_q;
  logic             missed_q;

  logic [POS_W-1:0]        cur_pos;
  logic signed [EXT_W-1:0] cur_ext;
  logic signed [EXT_W-1:0] step_ext;
  logic signed [EXT_W-1:0] next_ext;
  logic signed [EXT_W-1:0] upd_ext;
  logic [POS_W-1:0]        upd_pos;

`ifndef BAR_SCHED_WRAP_EN
  // Direction per bar: 1 = moving up (+step), 0 = moving down (-step).
  logic [NUM_BARS-1:0] dir_q;
  logic                cur_dir;
  logic                upd_dir;
`endif

  // Shared datapath: widened by two bits so the pre-clamp sum never overflows.
  always_comb begin
    cur_pos  = shadow_q[idx_q];
    cur_ext  = $signed({{2{cur_pos[POS_W-1]}}, cur_pos});
    step_ext = $signed({{(EXT_W-4){1'b0}}, step_q});
`ifdef BAR_SCHED_WRAP_EN
    next_ext = cur_ext + step_ext;
    upd_ext  = next_ext;
    if (next_ext > AMP_POS) upd_ext = next_ext - WRAP_SPAN;
`else
    cur_dir  = dir_q[idx_q];
    next_ext = cur_dir ? (cur_ext + step_ext) : (cur_ext - step_ext);
    upd_ext  = next_ext;
    upd_dir  = cur_dir;
    if (next_ext > AMP_POS) begin
      upd_ext = AMP_POS;
      upd_dir = 1'b0;
    end else if (next_ext < AMP_NEG) begin
      upd_ext = AMP_NEG;
      upd_dir = 1'b1;
    end
`endif
    upd_pos = POS_W'(upd_ext);
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      step_q   <= '0;
      done_q   <= 1'b0;
      missed_q <= 1'b0;
      for (int k = 0; k < NUM_BARS; k++) begin
        shadow_q[k]                  <= POS_W'(k * PHASE_SPACING);
        bar_pos_q[k*POS_W +: POS_W]  <= POS_W'(k * PHASE_SPACING);
      end
`ifndef BAR_SCHED_WRAP_EN
      dir_q <= '1;
`endif
    end else begin
      done_q   <= 1'b0;
      // Any tick outside IDLE (including the COMMIT cycle) is dropped and flagged.
      missed_q <= i_NewFrameTick && (state_q != S_IDLE);
      case (state_q)
        S_IDLE: begin
          if (i_NewFrameTick && !i_Pause) begin
            state_q <= S_UPDATE;
            idx_q   <= '0;
            step_q  <= i_Step;
          end
        end
        S_UPDATE: begin
          shadow_q[idx_q] <= upd_pos;
`ifndef BAR_SCHED_WRAP_EN
          dir_q[idx_q] <= upd_dir;
`endif
          if (idx_q == LAST_IDX) state_q <= S_COMMIT;
          else                   idx_q   <= idx_q + 1'b1;
        end
        S_COMMIT: begin
          for (int k = 0; k < NUM_BARS; k++) begin
            bar_pos_q[k*POS_W +: POS_W] <= shadow_q[k];
          end
          state_q <= S_IDLE;
          done_q  <= 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_BarPos     = bar_pos_q;
  assign o_Busy       = (state_q != S_IDLE);
  assign o_UpdateDone = done_q;
  assign o_MissedTick = missed_q;
  assign o_DbgState   = state_q;

endmodule
